// File: rtl/riscv_structures_pkg.sv
// Shared fetch/decode types for the pipeline front end.
package riscv_structures;

    localparam logic [31:0] FE_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instruction_value;
        logic [31:0] pc_value;
    } fe_to_de_s;

    typedef struct packed {
        logic [31:0] instruction_value;
        logic [31:0] pc_value;
    } fe_queue_entry_s;

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between the instruction memory response and decode.
// Flush has priority over push and pop.
module fetch_queue
    import riscv_structures::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  fe_queue_entry_s            push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count,
    output fe_queue_entry_s            head,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fe_queue_entry_s mem_q [DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push_ok, pop_ok;

    assign push_ok = push && !flush;
    assign pop_ok  = pop && !flush && (count_q != '0);

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_entry;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];
    assign empty = (count_q == '0);

    a_no_push_when_full: assert property (@(posedge clk) disable iff (reset)
        !(push && count_q == CW'(DEPTH)));

endmodule

// File: rtl/fetch_queued.sv
// Fetch stage with a prefetch queue, credit-throttled memory requests and
// branch redirect/flush; instr_mem has a fixed one-cycle read latency.
module fetch_queued
    import riscv_structures::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] RESET_NOP  = FE_NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_init,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic [31:0] imem_rsp_data,
    input  logic        de_ready,
    output logic        fe_valid,
    output fe_to_de_s   fe_to_de
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]     pc_q, pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;

    logic [CW-1:0]   q_count;
    logic            q_empty;
    fe_queue_entry_s q_head;
    fe_queue_entry_s push_entry;
    logic            push, pop, issue;
    logic [CW:0]     occupancy;

    // Credits count both queued entries and the response still in flight,
    // so a push can never find the queue full.
    assign occupancy = {1'b0, q_count} + (CW+1)'(inflight_q);
    assign issue     = !reset && !redirect_valid && (occupancy < (CW+1)'(FIFO_DEPTH));

    assign push       = inflight_q && !redirect_valid;
    assign push_entry = '{instruction_value: imem_rsp_data, pc_value: inflight_pc_q};
    assign fe_valid   = !q_empty && !redirect_valid;
    assign pop        = fe_valid && de_ready;

    assign imem_req_valid = issue;
    assign imem_req_addr  = reset ? pc_init : pc_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issue) begin
            pc_d          = pc_q + 32'd4;
            inflight_pc_d = pc_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= pc_init;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    always_comb begin
        fe_to_de.instruction_value = q_head.instruction_value;
        fe_to_de.pc_value          = q_head.pc_value;
        if (q_empty) begin
            fe_to_de.instruction_value = RESET_NOP;
            fe_to_de.pc_value          = '0;
        end
    end

    fetch_queue #(
        .DEPTH (FIFO_DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (q_count),
        .head       (q_head),
        .empty      (q_empty)
    );

endmodule

// File: tb/tb_fetch_queued.sv
// Randomized bench for fetch_queued against a transaction-level model:
// a list of fetched-but-unconsumed PCs, each visible two cycles after issue.
module tb_fetch_queued;
    import riscv_structures::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_init = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        de_ready = 1'b0;
    logic        fe_valid;
    fe_to_de_s   fe_to_de;

    fetch_queued #(.FIFO_DEPTH(DEPTH), .RESET_NOP(32'h0000_0013)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_init        (pc_init),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_data  (imem_rsp_data),
        .de_ready       (de_ready),
        .fe_valid       (fe_valid),
        .fe_to_de       (fe_to_de)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk) imem_rsp_data <= mem_word(imem_req_addr);

    typedef struct {
        logic [31:0] pc;
        int          vis;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] exp_pc;
    int          cyc;
    int          tests = 0;
    int          fails = 0;
    int          transfers = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Entered at posedge+1; returns at the next posedge+1.
    task automatic step(input logic rdv, input logic [31:0] rpc, input logic rdy);
        logic        iss, head_vis, vld;
        logic [63:0] head;
        redirect_valid = rdv;
        redirect_pc    = rpc;
        de_ready       = rdy;
        #3;
        iss      = !rdv && (pend.size() < DEPTH);
        head_vis = 1'b0;
        if (pend.size() != 0) head_vis = (pend[0].vis <= cyc);
        vld  = !rdv && head_vis;
        head = {32'h0000_0013, 32'h0};
        if (head_vis) head = {mem_word(pend[0].pc), pend[0].pc};
        check("req_valid", 64'(imem_req_valid), 64'(iss));
        check("req_addr", 64'(imem_req_addr), 64'(exp_pc));
        check("fe_valid", 64'(fe_valid), 64'(vld));
        if (!rdv) check("fe_to_de", 64'(fe_to_de), head);
        @(posedge clk);
        #1;
        cyc++;
        if (rdv) begin
            pend.delete();
            exp_pc = rpc & ~32'h3;
        end else begin
            if (vld && rdy) begin
                void'(pend.pop_front());
                transfers++;
            end
            if (iss) begin
                pend.push_back('{pc: exp_pc, vis: cyc + 1});
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    task automatic check_reset_outputs(input logic [31:0] pi);
        check("rst_req_valid", 64'(imem_req_valid), 64'(0));
        check("rst_req_addr", 64'(imem_req_addr), 64'(pi));
        check("rst_fe_valid", 64'(fe_valid), 64'(0));
        check("rst_fe_to_de", 64'(fe_to_de), {32'h0000_0013, 32'h0});
    endtask

    task automatic release_reset(input logic [31:0] pi);
        reset = 1'b0;
        pend.delete();
        exp_pc = pi;
        cyc = 0;
    endtask

    task automatic do_reset(input logic [31:0] pi);
        reset = 1'b1;
        pc_init = pi;
        redirect_valid = 1'b0;
        de_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs(pi);
        release_reset(pi);
    endtask

    // Reset asserted between clock edges; outputs must clear before any edge.
    task automatic async_reset(input logic [31:0] pi);
        #2;
        pc_init = pi;
        redirect_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_reset_outputs(pi);
        @(posedge clk);
        #1;
        release_reset(pi);
    endtask

    initial begin
        exp_pc = 32'h0;
        cyc = 0;

        // Streaming from 0x100, then stall and release.
        do_reset(32'h0000_0100);
        repeat (12) step(1'b0, 32'h0, 1'b1);
        do_reset(32'h0000_0100);
        repeat (10) step(1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 32'h0, 1'b1);

        // Redirect in the cycle the 0x108 response arrives.
        do_reset(32'h0000_0100);
        repeat (3) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_2002, 1'b1);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // PC wrap.
        do_reset(32'hFFFF_FFF8);
        repeat (8) step(1'b0, 32'h0, 1'b1);

        // Async reset with a full queue.
        do_reset(32'h0000_0400);
        repeat (8) step(1'b0, 32'h0, 1'b0);
        async_reset(32'h0000_0800);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Redirect with ready high while entries are queued, then held redirect.
        do_reset(32'h0000_0100);
        repeat (4) step(1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h0000_3000, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1);
        step(1'b1, 32'h0000_4000, 1'b1);
        step(1'b1, 32'h0000_5001, 1'b0);
        repeat (6) step(1'b0, 32'h0, 1'b1);

        // Randomized traffic.
        do_reset($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                async_reset($urandom);
            end else begin
                step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) != 0);
            end
        end

        check("transfers_seen", 64'(transfers > 500), 64'(1));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
